// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int ADDR_W     = 32;
  localparam int INST_W     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc4;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/ack bus and decode-side pop bus of the fetch front end.
interface fetch_prefetch_queue_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              id_ready;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc4;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc4,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc4,
    output imem_ack, imem_rdata, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {inst, pc4} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CNT_W-1:0] count,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues one outstanding imem read, queues returns for decode.
// Optional FETCH_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_prefetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              issue, accept, bypass, push, pop;
  fetch_entry_t      push_entry, head;
  logic [CNT_W-1:0]  count;
  logic              empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect && (count < CNT_W'(DEPTH))) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          state_d = IDLE;
          accept  = ~redirect;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = accept & empty & bus.id_ready;
`else
  assign bypass = 1'b0;
`endif

  // A redirect wins over everything: the flush discards both the pushed word and the pop.
  assign push       = accept & ~bypass;
  assign pop        = ~redirect & ~empty & bus.id_ready;
  assign push_entry = '{inst: bus.imem_rdata, pc4: req_addr_q + ADDR_W'(WORD_BYTES)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      req_addr_q <= word_align(RESET_PC);
    end else begin
      state_q <= state_d;
      if (redirect)    fetch_pc_q <= word_align(redirect_pc);
      else if (accept) fetch_pc_q <= fetch_pc_q + ADDR_W'(WORD_BYTES);
      if (issue)       req_addr_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // Address is captured at issue so it stays stable through DROP even as fetch_pc moves.
  assign bus.imem_req  = (state_q != IDLE);
  assign bus.imem_addr = req_addr_q;

  always_comb begin
    bus.id_valid = ~empty;
    bus.id_inst  = empty ? '0 : head.inst;
    bus.id_pc4   = empty ? '0 : head.pc4;
    if (bypass) begin
      bus.id_valid = 1'b1;
      bus.id_inst  = bus.imem_rdata;
      bus.id_pc4   = req_addr_q + ADDR_W'(WORD_BYTES);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_prefetch_queue_if bus();

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  // Transaction-level reference: a queue of decoded words plus the one outstanding request.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_pend;
  bit          m_drop;

  task automatic model_step();
    bit ack;
    int sz;
    if (rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_pend = 0;
      m_drop = 0;
    end else begin
      ack = m_pend && (bus.imem_ack === 1'b1);
      sz  = mq.size();
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (ack)         m_pend = 0;
        else if (m_pend) m_drop = 1;
      end else begin
        if (sz > 0 && bus.id_ready) void'(mq.pop_front());
        if (ack) begin
          m_pend = 0;
          if (!m_drop) begin
            mq.push_back('{inst: mem_word(m_addr), pc4: m_addr + 32'd4});
            m_pc = m_pc + 32'd4;
          end
        end else if (!m_pend && sz < DEPTH) begin
          m_pend = 1;
          m_addr = m_pc;
          m_drop = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, m_pend});
    if (m_pend) check("imem_addr", bus.imem_addr, m_addr);
    check("id_valid", {31'b0, bus.id_valid}, {31'b0, (mq.size() > 0)});
    if (mq.size() > 0) begin
      check("id_inst", bus.id_inst, mq[0].inst);
      check("id_pc4", bus.id_pc4, mq[0].pc4);
    end
  end

  task automatic next();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      next();
      n++;
    end
    check("req_timeout", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic respond(input int lat);
    repeat (lat) next();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mem_word(bus.imem_addr);
    next();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit in_req;
    int lat;

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    next();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst_inst", bus.id_inst, 32'd0);
    check("rst_pc4", bus.id_pc4, 32'd0);
    next();
    rst = 1'b0;

    // 1: sequential fetch, ack one cycle after req, decode always ready
    bus.id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req();
      check("t1_addr", bus.imem_addr, 32'(4 * k));
      respond(1);
      check("t1_valid", {31'b0, bus.id_valid}, 32'd1);
      check("t1_pc4", bus.id_pc4, 32'(4 * k + 4));
      check("t1_inst", bus.id_inst, mem_word(32'(4 * k)));
    end
    next();

    // 2: decode stalled, fill to DEPTH with random latency, then drain in order
    bus.id_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_req();
      check("t2_addr", bus.imem_addr, 32'(16 + 4 * k));
      respond($urandom_range(0, 3));
    end
    for (int i = 0; i < 6; i++) begin
      check("t2_full_noreq", {31'b0, bus.imem_req}, 32'd0);
      check("t2_full_head", bus.id_pc4, 32'd20);
      next();
    end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", {31'b0, bus.id_valid}, 32'd1);
      check("t2_drain_pc4", bus.id_pc4, 32'(20 + 4 * i));
      next();
    end

    // 4: redirect coincident with ack while two words are queued
    bus.id_ready = 1'b0;
    wait_req();
    check("t4_addr0", bus.imem_addr, 32'd32);
    respond(0);
    wait_req();
    check("t4_addr1", bus.imem_addr, 32'd36);
    respond(2);
    wait_req();
    check("t4_addr2", bus.imem_addr, 32'd40);
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'd40);
    redirect = 1'b1; redirect_pc = 32'h8;
    next();
    bus.imem_ack = 1'b0; redirect = 1'b0;
    check("t4_flushed", {31'b0, bus.id_valid}, 32'd0);
    check("t4_idle", {31'b0, bus.imem_req}, 32'd0);
    next();
    check("t4_new_req", {31'b0, bus.imem_req}, 32'd1);
    check("t4_new_addr", bus.imem_addr, 32'h8);

    // 3: redirect while waiting on 0x8, ack arrives later and is dropped
    redirect = 1'b1; redirect_pc = 32'h100;
    next();
    redirect = 1'b0;
    check("t3_drop_req", {31'b0, bus.imem_req}, 32'd1);
    check("t3_drop_addr", bus.imem_addr, 32'h8);
    next();
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(32'h8);
    next();
    bus.imem_ack = 1'b0;
    check("t3_discarded", {31'b0, bus.id_valid}, 32'd0);
    wait_req();
    check("t3_addr", bus.imem_addr, 32'h100);
    bus.id_ready = 1'b1;
    respond(0);
    check("t3_valid", {31'b0, bus.id_valid}, 32'd1);
    check("t3_pc4", bus.id_pc4, 32'h104);
    check("t3_inst", bus.id_inst, mem_word(32'h100));

    // 5: PC wrap at the top of the address space, low redirect bits ignored
    wait_req();
    bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(bus.imem_addr);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    next();
    bus.imem_ack = 1'b0; redirect = 1'b0;
    wait_req();
    check("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
    respond(1);
    check("t5_pc4_wrap", bus.id_pc4, 32'h0);
    wait_req();
    check("t5_next_addr", bus.imem_addr, 32'h0);

    // 6: reset while waiting; a late ack must not produce a word
    rst = 1'b1;
    next();
    rst = 1'b0;
    check("t6_req", {31'b0, bus.imem_req}, 32'd0);
    check("t6_valid", {31'b0, bus.id_valid}, 32'd0);
    check("t6_inst", bus.id_inst, 32'd0);
    check("t6_pc4", bus.id_pc4, 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    next();
    bus.imem_ack = 1'b0;
    check("t6_late_ack", {31'b0, bus.id_valid}, 32'd0);

    // Randomized traffic: stalls, redirects (some near the wrap point), rare resets
    in_req = 0;
    lat    = -1;
    for (int c = 0; c < 2000; c++) begin
      bus.id_ready = ($urandom_range(0, 9) < 7);
      redirect     = ($urandom_range(0, 39) == 0);
      redirect_pc  = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom_range(0, 255));
      rst          = ($urandom_range(0, 299) == 0);
      if (bus.imem_req !== 1'b1) begin
        in_req = 0;
      end else if (!in_req) begin
        in_req = 1;
        lat    = $urandom_range(0, 3);
      end
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      if (in_req) begin
        if (lat == 0) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          lat = -1;
        end else if (lat > 0) begin
          lat--;
        end
      end
      next();
    end

    rst = 1'b0; redirect = 1'b0; bus.imem_ack = 1'b0;
    repeat (4) next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
